// File: rtl/nco_phase_accumulator_if.sv
// Phase-word / phase-out bundle between the frequency stage, the NCO accumulator and the CORDIC mixer.
interface nco_phase_accumulator_if #(
    parameter int OUT_WIDTH = 20
);
    logic [31:0]          phase_word_in;
    logic                 enable;
    logic                 phase_reset;
    logic [OUT_WIDTH-1:0] phase_out;
    logic                 phase_valid;
    logic                 freq_changed;
    logic [31:0]          active_word;

    modport master (
        output phase_word_in, enable, phase_reset,
        input  phase_out, phase_valid, freq_changed, active_word
    );

    modport slave (
        input  phase_word_in, enable, phase_reset,
        output phase_out, phase_valid, freq_changed, active_word
    );
endinterface

// File: rtl/nco_phase_accumulator.sv
// NCO phase accumulator with a CDC-tearing stability filter on the incoming phase word.
// Optional output dither is enabled by defining NCO_PHASE_DITHER_EN.
module nco_phase_accumulator #(
    parameter int OUT_WIDTH    = 20,
    parameter int STABLE_COUNT = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    nco_phase_accumulator_if.slave bus
);
    localparam int CW = 4;

    logic [31:0]          prev_word_q;
    logic [31:0]          active_word_q;
    logic [31:0]          acc_q;
    logic [CW-1:0]        stab_cnt_q;
    logic [CW-1:0]        stab_cnt_d;
    logic [OUT_WIDTH-1:0] phase_out_q;
    logic                 phase_valid_q;
    logic                 freq_changed_q;
    logic                 same_w;
    logic                 load_w;
    logic [31:0]          out_sum_w;

    assign same_w = (bus.phase_word_in == prev_word_q);
    // A word is trusted only after it has been seen unchanged for STABLE_COUNT+1 edges.
    assign load_w = same_w && (stab_cnt_q >= CW'(STABLE_COUNT - 1))
                    && (bus.phase_word_in != active_word_q);

    always_comb begin
        stab_cnt_d = '0;
        if (same_w) begin
            stab_cnt_d = (stab_cnt_q == CW'(STABLE_COUNT)) ? stab_cnt_q : stab_cnt_q + CW'(1);
        end
    end

`ifdef NCO_PHASE_DITHER_EN
    localparam int          DW    = ((32 - OUT_WIDTH) > 24) ? 24 : (32 - OUT_WIDTH);
    localparam logic [31:0] DMASK = 32'((64'd1 << DW) - 64'd1);

    logic [23:0] lfsr_q;
    logic [23:0] lfsr_d;
    logic [31:0] dither_w;

    assign lfsr_d    = {lfsr_q[22:0], lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16]};
    assign dither_w  = {8'h00, lfsr_q} & DMASK;
    assign out_sum_w = acc_q + dither_w;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= 24'h000001;
        end else if (bus.enable && !bus.phase_reset) begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign out_sum_w = acc_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_word_q    <= '0;
            stab_cnt_q     <= '0;
            active_word_q  <= '0;
            freq_changed_q <= 1'b0;
            acc_q          <= '0;
            phase_out_q    <= '0;
            phase_valid_q  <= 1'b0;
        end else begin
            prev_word_q    <= bus.phase_word_in;
            stab_cnt_q     <= stab_cnt_d;
            freq_changed_q <= load_w;
            if (load_w) begin
                active_word_q <= bus.phase_word_in;
            end
            // The accumulator uses the pre-load word, so a load never tears an increment.
            if (bus.phase_reset) begin
                acc_q         <= '0;
                phase_out_q   <= '0;
                phase_valid_q <= bus.enable;
            end else if (bus.enable) begin
                phase_out_q   <= out_sum_w[31 -: OUT_WIDTH];
                acc_q         <= acc_q + active_word_q;
                phase_valid_q <= 1'b1;
            end else begin
                phase_valid_q <= 1'b0;
            end
        end
    end

    assign bus.phase_out    = phase_out_q;
    assign bus.phase_valid  = phase_valid_q;
    assign bus.freq_changed = freq_changed_q;
    assign bus.active_word  = active_word_q;
endmodule

// File: doc/nco_phase_accumulator.md
Name: nco_phase_accumulator

Overview:
- Downstream of the frequency-to-phase stage.
- Consumes the 32-bit phase word after it has been double-registered into the clock domain.
- Qualifies the word against multi-bit CDC tearing, accumulates it into a 32-bit NCO phase, and presents a truncated phase plus valid strobe to the CORDIC mixer.
- Free-running phase and loads are glitch-free, so a frequency change never injects a torn intermediate frequency.

Parameters:
- OUT_WIDTH, 20: width of phase_out handed to CORDIC (MSBs of the accumulator); legal range 8..32.
- STABLE_COUNT, 2: number of consecutive equal-sample comparisons required before a new phase word is accepted; legal range 1..15.

Ports:
- clock  in  1  master clock (122.88 MHz domain).
- reset  in  1  asynchronous, active-high reset.
- phase_word_in  in  32  synchronised phase increment from the upstream stage; may be torn for a cycle when it changes.
- enable  in  1  advance the accumulator this cycle (sample strobe).
- phase_reset  in  1  synchronous clear of the accumulator (phase alignment).
- phase_out  out  OUT_WIDTH  truncated phase to CORDIC.
- phase_valid  out  1  phase_out updated this cycle.
- freq_changed  out  1  one-cycle pulse when active_word loads a new value.
- active_word  out  32  increment currently in use.

Behaviour:
- Async reset clears all registers to 0: prev_word, stab_cnt, active_word, acc, phase_out, phase_valid, freq_changed, and the dither LFSR (seed, see below).
- Stability filter, evaluated every clock edge, independent of enable:
  - prev_word <= phase_word_in.
  - If phase_word_in == prev_word, stab_cnt increments, saturating at STABLE_COUNT; otherwise stab_cnt <= 0.
  - Load condition: (phase_word_in == prev_word) && (stab_cnt >= STABLE_COUNT-1) && (phase_word_in != active_word). When met, active_word <= phase_word_in and freq_changed <= 1 for exactly one cycle. Otherwise freq_changed <= 0.
  - Net effect: a new word must be held for STABLE_COUNT+1 edges. With the default, a word presented before edge 1 is loaded at edge 3.
  - Reloading the same value produces no pulse.
- Accumulator:
  - acc is 32 bits and wraps modulo 2^32 with no saturation.
  - If phase_reset is high: acc <= 0, phase_out <= 0, phase_valid <= enable. phase_reset wins over enable.
  - Else if enable is high: phase_out <= acc[31:32-OUT_WIDTH] (pre-increment value), acc <= acc + active_word, phase_valid <= 1.
  - Else: acc and phase_out hold, phase_valid <= 0.
- Latency:
  - First valid sample after reset or phase_reset is 0.
  - A new active_word affects the acc update at the edge after the load edge. If enable is high on the load edge, the increment used is the old word.
- Simultaneous events: a load and enable on the same edge use the pre-load active_word; a load and phase_reset are independent (both occur).
- Reset mid-operation: everything returns to reset values immediately. After release, a nonzero held phase_word_in loads at the (STABLE_COUNT+1)th edge.

Optional Feature:
- Macro: NCO_PHASE_DITHER_EN.
- Defined:
  - A 24-bit Fibonacci LFSR (taps 24,23,22,17; seed 24'h000001 on reset) advances on each cycle where enable is high and phase_reset is low.
  - Its low (32-OUT_WIDTH) bits (zero-extended; truncated to 24 if wider) are added to acc in the output path only, before truncation.
  - phase_out <= (acc + dither)[31:32-OUT_WIDTH]. acc itself is never dithered.
  - phase_reset zeroes phase_out but does not reseed the LFSR.
- Not defined: plain truncation; the LFSR logic is absent.

Test Plan:
- Reset release, phase_word_in=32'h1000_0000 held, enable=1 from edge 5 → freq_changed pulses once after edge 3. phase_out sequence is 0x00000, 0x10000, 0x20000 … 0xF0000, then 0x00000 (wrap after 16 samples).
- phase_word_in alternates 32'h1234_5678 / 32'h8765_4321 every clock for 50 cycles → active_word stays 0, freq_changed never asserts.
- Steady 32'h0100_0000, then one-cycle glitch to 32'hFFFF_FFFF, then return → no load, no pulse, accumulation uninterrupted. Repeat with STABLE_COUNT=1 → still no load (the glitch lasts 1 edge; 2 are needed).
- enable=1 with phase_reset pulsed on the cycle acc=32'h3000_0000 → phase_out=0 and phase_valid=1 that cycle; next sample 0, then 0x10000 (word 32'h1000_0000).
- Word changes 32'h1000_0000 → 32'h2000_0000 with enable continuously high → the increment on the load edge is 0x1000_0000, and 0x2000_0000 applies from the next edge.
- With NCO_PHASE_DITHER_EN and word 0 → phase_out stays in {0x00000, 0x00001}. The LFSR never reaches all-zero over 2^24 enabled cycles.
